// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit -- fetches one memory word per cycle, assembles big-endian instructions
// into an in-order queue, and supports redirect flushes.  Rev 1.0
module fetch_unit #(
  parameter int ADDR_BITS     = 8,
  parameter int MEM_DATA_BITS = 8,
  parameter int INSTR_BYTES   = 2,
  parameter int QUEUE_DEPTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic [ADDR_BITS-1:0]                 mem_address,
  output logic                                 mem_read_en,
  input  logic [MEM_DATA_BITS-1:0]             mem_rdata,
  input  logic                                 redirect_valid,
  input  logic [ADDR_BITS-1:0]                 redirect_addr,
  output logic                                 instr_valid,
  output logic [INSTR_BYTES*MEM_DATA_BITS-1:0] instr,
  output logic [ADDR_BITS-1:0]                 instr_pc,
  input  logic                                 instr_ready,
  output logic [ADDR_BITS-1:0]                 fetch_pc
);
  localparam int IW = INSTR_BYTES * MEM_DATA_BITS;
  localparam int AW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam int QW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(INSTR_BYTES - 1);
  localparam logic [QW-1:0] DEPTH     = QW'(QUEUE_DEPTH);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;
  state_t state, state_next;

  // Slot 0 is the queue head and drives instr/instr_pc directly.
  logic [QUEUE_DEPTH-1:0][IW-1:0]        q_instr, q_instr_next;
  logic [QUEUE_DEPTH-1:0][ADDR_BITS-1:0] q_pc, q_pc_next;
  logic [QW-1:0]        count, count_next, wr_slot;
  logic [AW-1:0]        asm_cnt;
  logic [IW-1:0]        asm_data, word_full;
  logic [ADDR_BITS-1:0] asm_pc, word_pc;
  logic                 take, push, pop, issue;

  assign instr    = q_instr[0];
  assign instr_pc = q_pc[0];

  always_comb begin
    state_next   = state;
    take         = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    issue        = 1'b0;
    count_next   = count;
    word_full    = (asm_data << MEM_DATA_BITS) | IW'(mem_rdata);
    word_pc      = (asm_cnt == '0) ? mem_address : asm_pc;
    q_instr_next = q_instr;
    q_pc_next    = q_pc;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        take       = mem_read_en & ~redirect_valid;
        push       = take && (asm_cnt == LAST_WORD);
        pop        = instr_valid & instr_ready & ~redirect_valid;
        count_next = count + QW'(push) - QW'(pop);
        // Space is judged after this edge's push/pop, so a pop frees a slot immediately.
        issue      = ~redirect_valid && (count_next < DEPTH);
      end
      default: state_next = IDLE;
    endcase
    wr_slot = count - QW'(pop);
    if (pop) begin
      q_instr_next = q_instr >> IW;
      q_pc_next    = q_pc >> ADDR_BITS;
    end
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (push && (wr_slot == QW'(i))) begin
        q_instr_next[i] = word_full;
        q_pc_next[i]    = word_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      mem_address <= '0;
      mem_read_en <= 1'b0;
      instr_valid <= 1'b0;
      count       <= '0;
      asm_cnt     <= '0;
      asm_data    <= '0;
      asm_pc      <= '0;
      q_instr     <= '0;
      q_pc        <= '0;
    end else begin
      state       <= state_next;
      mem_read_en <= issue;
      q_instr     <= q_instr_next;
      q_pc        <= q_pc_next;
      if (issue) begin
        mem_address <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (redirect_valid) begin
        fetch_pc    <= redirect_addr;
        count       <= '0;
        instr_valid <= 1'b0;
        asm_cnt     <= '0;
      end else begin
        count       <= count_next;
        instr_valid <= (count_next != '0);
        if (take) begin
          asm_data <= word_full;
          asm_pc   <= word_pc;
          asm_cnt  <= push ? '0 : asm_cnt + 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit -- directed scenarios with a queue-based reference model for the
// default configuration, plus an ordering scoreboard for a 1-word/1-deep instance.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- default-parameter DUT ----------------
  logic [7:0]  mem [256];
  logic        rst, ready, redir_v;
  logic [7:0]  redir_a, addr0, rdata0, pc0, fpc0;
  logic        rd0, valid0;
  logic [15:0] instr0;
  assign rdata0 = mem[addr0];

  fetch_unit dut (
    .clk(clk), .reset(rst),
    .mem_address(addr0), .mem_read_en(rd0), .mem_rdata(rdata0),
    .redirect_valid(redir_v), .redirect_addr(redir_a),
    .instr_valid(valid0), .instr(instr0), .instr_pc(pc0),
    .instr_ready(ready), .fetch_pc(fpc0)
  );

  // Reference model: pending request, bytes collected so far, and the queue contents.
  typedef struct { logic [15:0] ins; logic [7:0] pc; } ent_t;
  ent_t       mq[$];
  logic [7:0] masm[$];
  logic [7:0] m_pc = 8'h00, m_addr = 8'h00, m_asm_pc = 8'h00;
  bit         m_run = 0, m_req = 0, m_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); masm.delete();
      m_pc = 8'h00; m_addr = 8'h00; m_req = 0; m_run = 0; m_live = 1;
    end else if (redir_v) begin
      mq.delete(); masm.delete();
      m_pc = redir_a; m_req = 0; m_run = 1;
    end else if (!m_run) begin
      m_run = 1; m_req = 0;
    end else begin
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      if (m_req) begin
        if (masm.size() == 0) m_asm_pc = m_addr;
        masm.push_back(mem[m_addr]);
        if (masm.size() == 2) begin
          mq.push_back('{ins: {masm[0], masm[1]}, pc: m_asm_pc});
          masm.delete();
        end
      end
      if (mq.size() < 2) begin
        m_addr = m_pc; m_pc = m_pc + 8'd1; m_req = 1;
      end else begin
        m_req = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_valid", 32'(valid0), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("m_instr", 32'(instr0), 32'(mq[0].ins));
        chk("m_instr_pc", 32'(pc0), 32'(mq[0].pc));
      end
      chk("m_rd_en", 32'(rd0), 32'(m_req));
      if (m_req) chk("m_addr", 32'(addr0), 32'(m_addr));
      chk("m_fetch_pc", 32'(fpc0), 32'(m_pc));
    end
  end

  // ---------------- INSTR_BYTES=1, QUEUE_DEPTH=1 DUT ----------------
  logic [7:0] mem1 [256];
  logic       rst1, ready1, rd1, valid1;
  logic [7:0] addr1, rdata1, instr1, pc1, fpc1;
  logic [7:0] exp_pc1 = 8'h00;
  int         xfers1 = 0;
  bit         d1_live = 0;
  assign rdata1 = mem1[addr1];

  fetch_unit #(.INSTR_BYTES(1), .QUEUE_DEPTH(1)) dut1 (
    .clk(clk), .reset(rst1),
    .mem_address(addr1), .mem_read_en(rd1), .mem_rdata(rdata1),
    .redirect_valid(1'b0), .redirect_addr(8'h00),
    .instr_valid(valid1), .instr(instr1), .instr_pc(pc1),
    .instr_ready(ready1), .fetch_pc(fpc1)
  );

  // Every accepted instruction must be the next address in order with matching data.
  always @(negedge clk) begin
    if (d1_live) begin
      chk("d1_no_overflow", 32'(valid1 & rd1), 32'h0);
      if (valid1 && ready1) begin
        chk("d1_pc_seq", 32'(pc1), 32'(exp_pc1));
        chk("d1_instr", 32'(instr1), 32'(mem1[exp_pc1]));
        exp_pc1 = exp_pc1 + 8'd1;
        xfers1++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i) ^ 8'hA5;
      mem1[i] = 8'(i * 7 + 3);
    end
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    mem[8'h40] = 8'hAB; mem[8'h41] = 8'hCD; mem[8'hFF] = 8'h11;
    rst = 1; ready = 0; redir_v = 0; redir_a = 8'h00;
    rst1 = 1; ready1 = 0;
    step(); step();

    // Reset values
    chk("rst_valid", 32'(valid0), 32'h0);
    chk("rst_instr", 32'(instr0), 32'h0);
    chk("rst_instr_pc", 32'(pc0), 32'h0);
    chk("rst_rd_en", 32'(rd0), 32'h0);
    chk("rst_addr", 32'(addr0), 32'h0);
    chk("rst_fetch_pc", 32'(fpc0), 32'h0);

    // First instruction at the 4th edge, second two edges later
    rst = 0; ready = 1;
    step(); step(); step();
    chk("A_e3_valid", 32'(valid0), 32'h0);
    step();
    chk("A_e4_valid", 32'(valid0), 32'h1);
    chk("A_e4_instr", 32'(instr0), 32'h1234);
    chk("A_e4_pc", 32'(pc0), 32'h00);
    step(); step();
    chk("A_e6_instr", 32'(instr0), 32'h5678);
    chk("A_e6_pc", 32'(pc0), 32'h02);

    // Back-pressure: queue fills and fetch stops; one pop admits exactly one more
    rst = 1; step();
    rst = 0; ready = 0;
    repeat (10) step();
    chk("B_full_rd_en", 32'(rd0), 32'h0);
    chk("B_full_fetch_pc", 32'(fpc0), 32'h04);
    chk("B_full_head", 32'(instr0), 32'h1234);
    ready = 1; step();
    ready = 0; repeat (6) step();
    chk("B_after_pop_fetch_pc", 32'(fpc0), 32'h06);
    chk("B_after_pop_head", 32'(instr0), 32'h5678);
    chk("B_after_pop_pc", 32'(pc0), 32'h02);
    chk("B_after_pop_rd_en", 32'(rd0), 32'h0);

    // Redirect mid-assembly with a non-empty queue and ready asserted
    rst = 1; step();
    rst = 0; ready = 0;
    repeat (5) step();
    chk("C_pre_valid", 32'(valid0), 32'h1);
    chk("C_pre_addr", 32'(addr0), 32'h03);
    redir_v = 1; redir_a = 8'h40; ready = 1;
    step();
    chk("C_flush_valid", 32'(valid0), 32'h0);
    chk("C_flush_rd_en", 32'(rd0), 32'h0);
    chk("C_flush_fetch_pc", 32'(fpc0), 32'h40);
    redir_v = 0;
    step();
    chk("C_first_addr", 32'(addr0), 32'h40);
    chk("C_first_rd_en", 32'(rd0), 32'h1);
    step();
    chk("C_no_partial", 32'(valid0), 32'h0);
    step();
    chk("C_instr", 32'(instr0), 32'hABCD);
    chk("C_instr_pc", 32'(pc0), 32'h40);

    // Reset with a full queue, then with a request in flight
    ready = 0; rst = 1; step();
    rst = 0; repeat (10) step();
    chk("E_full_valid", 32'(valid0), 32'h1);
    rst = 1; step();
    chk("E_rst_full_valid", 32'(valid0), 32'h0);
    chk("E_rst_full_rd_en", 32'(rd0), 32'h0);
    chk("E_rst_full_fetch_pc", 32'(fpc0), 32'h0);
    rst = 0; repeat (5) step();
    chk("E_inflight_rd_en", 32'(rd0), 32'h1);
    rst = 1; step();
    chk("E_rst_inflight_valid", 32'(valid0), 32'h0);
    chk("E_rst_inflight_rd_en", 32'(rd0), 32'h0);
    chk("E_rst_inflight_fetch_pc", 32'(fpc0), 32'h0);
    rst = 0; repeat (2) step();
    chk("E_refetch_addr", 32'(addr0), 32'h00);
    repeat (2) step();
    chk("E_refetch_instr", 32'(instr0), 32'h1234);
    chk("E_refetch_pc", 32'(pc0), 32'h00);

    // Back-to-back redirects (last wins) to an instruction straddling the top address
    mem[8'h00] = 8'h22;
    rst = 1; step();
    rst = 0; repeat (3) step();
    redir_v = 1; redir_a = 8'h80; step();
    redir_a = 8'hFF; step();
    redir_v = 0; step();
    chk("D_addr_ff", 32'(addr0), 32'hFF);
    step();
    chk("D_addr_wrap", 32'(addr0), 32'h00);
    chk("D_fetch_pc_wrap", 32'(fpc0), 32'h01);
    step();
    chk("D_valid", 32'(valid0), 32'h1);
    chk("D_instr", 32'(instr0), 32'h1122);
    chk("D_instr_pc", 32'(pc0), 32'hFF);

    // Single-word, single-entry instance: constant ready, then toggling ready
    step();
    rst1 = 0; ready1 = 1; d1_live = 1;
    repeat (40) step();
    for (int k = 0; k < 40; k++) begin
      ready1 = ~ready1;
      step();
    end
    ready1 = 0;
    repeat (4) step();
    chk("d1_progress", 32'(xfers1 >= 30), 32'h1);
    chk("d1_hold_valid", 32'(valid1), 32'h1);
    chk("d1_hold_pc", 32'(pc1), 32'(exp_pc1));
    chk("d1_hold_fetch_pc", 32'(fpc1), 32'(exp_pc1 + 8'd1));
    chk("d1_hold_rd_en", 32'(rd1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
`default_nettype wire
